// File: rtl/reg_wb_if.sv
// reg_wb_if: groups the register write-back bus signals.
//   ALU result : alu_valid, alu_rd, alu_data
//   Load result: ld_valid, ld_ready, ld_rd, ld_data
//   Load issue : ld_issue, ld_issue_rd
//   Decode     : rs1, rs2, stall
//   RF write   : RegWEn, AddrD, DataD
// The master modport drives the requests. The slave modport is the write-back block.
interface reg_wb_if #(
    parameter int RAWIDTH = 5,
    parameter int DWIDTH  = 32
);
    logic               alu_valid;
    logic [RAWIDTH-1:0] alu_rd;
    logic [DWIDTH-1:0]  alu_data;
    logic               ld_valid;
    logic               ld_ready;
    logic [RAWIDTH-1:0] ld_rd;
    logic [DWIDTH-1:0]  ld_data;
    logic               ld_issue;
    logic [RAWIDTH-1:0] ld_issue_rd;
    logic [RAWIDTH-1:0] rs1;
    logic [RAWIDTH-1:0] rs2;
    logic               stall;
    logic               RegWEn;
    logic [RAWIDTH-1:0] AddrD;
    logic [DWIDTH-1:0]  DataD;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               ld_issue, ld_issue_rd, rs1, rs2,
        input  ld_ready, stall, RegWEn, AddrD, DataD
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               ld_issue, ld_issue_rd, rs1, rs2,
        output ld_ready, stall, RegWEn, AddrD, DataD
    );
endinterface

// File: rtl/reg_wb.sv
// reg_wb: register-file write-back arbiter.
// Single-cycle ALU results take priority. Load results queue in a DEPTH-entry FIFO
// and drain whenever the ALU is idle. A per-register pending bit tracks
// outstanding loads. The decode stage stalls when a source operand still waits on a load.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - reg_wb_if.slave (ALU/load inputs, ld_ready, stall, RegWEn/AddrD/DataD)
module reg_wb #(
    parameter int RAWIDTH = 5,
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 4
) (
    input logic     clk,
    input logic     rst,
    reg_wb_if.slave bus
);
    localparam int PW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 1 << RAWIDTH;

    logic [RAWIDTH-1:0] fifoRd   [DEPTH];
    logic [DWIDTH-1:0]  fifoData [DEPTH];
    logic [PW-1:0]      wrPtr;
    logic [PW-1:0]      rdPtr;
    logic [CW-1:0]      count;

    logic               wen;
    logic [RAWIDTH-1:0] addr;
    logic [DWIDTH-1:0]  data;
    logic               fromFifo;
    logic [NREG-1:0]    pending;

    logic push;
    logic pop;
    logic ready;

    // Ready is based only on the registered occupancy. A pop in the same cycle does not free a slot early.
    assign ready = (count < CW'(DEPTH));
    assign push  = bus.ld_valid && ready;
    assign pop   = !bus.alu_valid && (count != '0);

    assign bus.ld_ready = ready;
    assign bus.RegWEn   = wen;
    assign bus.AddrD    = addr;
    assign bus.DataD    = data;
    // pending[0] is never set, so x0 never stalls.
    assign bus.stall    = pending[bus.rs1] || pending[bus.rs2];

    always_ff @(posedge clk) begin
        if (push) begin
            fifoRd[wrPtr]   <= bus.ld_rd;
            fifoData[wrPtr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            wen      <= 1'b0;
            addr     <= '0;
            data     <= '0;
            fromFifo <= 1'b0;
            pending  <= '0;
        end else begin
            // Pointers are DEPTH-sized, so they wrap without help (DEPTH is a power of two).
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bus.alu_valid) begin
                wen      <= (bus.alu_rd != '0);
                addr     <= bus.alu_rd;
                data     <= bus.alu_data;
                fromFifo <= 1'b0;
            end else if (pop) begin
                wen      <= (fifoRd[rdPtr] != '0);
                addr     <= fifoRd[rdPtr];
                data     <= fifoData[rdPtr];
                fromFifo <= 1'b1;
            end else begin
                wen      <= 1'b0;
                fromFifo <= 1'b0;
            end

            // A load commit visible this cycle clears its bit. A new issue is written later, so it wins on a collision.
            if (wen && fromFifo)
                pending[addr] <= 1'b0;
            if (bus.ld_issue && (bus.ld_issue_rd != '0))
                pending[bus.ld_issue_rd] <= 1'b1;
        end
    end
endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 SHALL have parameter RAWIDTH, default 5, register address width.
REQ-002 SHALL have parameter DWIDTH, default 32, register data width.
REQ-003 SHALL have parameter DEPTH, default 4, load-result FIFO entries, power of two and at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port alu_valid, input, 1, single-cycle result present this cycle.
REQ-007 SHALL have ports alu_rd, input, RAWIDTH, and alu_data, input, DWIDTH, which carry the ALU destination and result.
REQ-008 SHALL have port ld_valid, input, 1, load result offered.
REQ-009 SHALL have port ld_ready, output, 1, load result accepted when both ld_valid and ld_ready are high.
REQ-010 SHALL have ports ld_rd, input, RAWIDTH, and ld_data, input, DWIDTH, which carry the load destination and data.
REQ-011 SHALL have ports ld_issue, input, 1, and ld_issue_rd, input, RAWIDTH, which mark a load issued to that destination.
REQ-012 SHALL have ports rs1 and rs2, input, RAWIDTH each, which are decode source addresses.
REQ-013 SHALL have port stall, output, 1, source operand awaits a load.
REQ-014 SHALL have ports RegWEn, output, 1; AddrD, output, RAWIDTH; and DataD, output, DWIDTH, which form the register-file write port.

Function
REQ-015 SHALL arbitrate each cycle: alu_valid wins; else FIFO non-empty pops head; else no write.
REQ-016 SHALL register the selected write onto RegWEn/AddrD/DataD at the next edge: ALU latency 1 cycle, load latency at least 2 cycles (push edge, then select/pop edge).
REQ-017 SHALL drive RegWEn low whenever selected rd is 0; the entry is still consumed, and AddrD/DataD still update.
REQ-018 SHALL hold RegWEn low for a cycle with no selection; AddrD/DataD hold their previous values.
REQ-019 SHALL assert ld_ready exactly when FIFO occupancy is below DEPTH, from registered count only, with no same-cycle pop bypass.
REQ-020 SHALL push and pop in the same cycle without changing occupancy; pointers wrap modulo DEPTH.
REQ-021 SHALL never drop or reorder accepted loads; loads leave in acceptance order.
REQ-022 SHALL keep a pending bit per register: ld_issue with nonzero ld_issue_rd sets it; ld_issue with ld_issue_rd equal to 0 is ignored.
REQ-023 SHALL clear pending[r] at the edge ending a cycle in which RegWEn is high, AddrD equals r, and the write originated from the FIFO.
REQ-024 SHALL let set win when set and clear target the same register in the same cycle.
REQ-025 SHALL not alter pending bits on ALU writes.
REQ-026 SHALL drive stall combinationally as pending[rs1] OR pending[rs2]; pending[0] reads 0.
REQ-027 SHALL leave ld_data content unconstrained by ld_rd value; any DWIDTH pattern passes unmodified.

Reset
REQ-028 SHALL, while rst is high at an edge, clear FIFO pointers, count, all pending bits, RegWEn, AddrD, DataD, and the origin flag to 0.
REQ-029 SHALL drive ld_ready high and stall low in the cycle after reset.
REQ-030 SHALL discard in-flight FIFO contents and ignore alu_valid, ld_valid, and ld_issue sampled at a reset edge.

Verification
REQ-031 SHALL be verified as: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> RegWEn=1, AddrD=5, DataD=0xDEADBEEF at N+1.
REQ-032 SHALL be verified as: ld_issue rd=7; load 0x12345678 rd=7 accepted at N with ALU idle -> write visible N+2; stall with rs1=7 is high through N+2 and low at N+3.
REQ-033 SHALL be verified as: 4 loads pushed back-to-back while alu_valid is held high -> ld_ready low after the 4th; drop alu_valid -> writes drain in order, one per cycle, and ld_ready returns high the cycle after the first pop.
REQ-034 SHALL be verified as: ALU rd=0 or load rd=0 -> RegWEn stays low and the FIFO still advances.
REQ-035 SHALL be verified as: ld_issue rd=9 in the same cycle as the FIFO write to x9 commits -> pending[9] remains 1 and stall stays high for rs2=9.
REQ-036 SHALL be verified as: rst asserted with 3 loads queued and pending bits set -> next cycle ld_ready=1, stall=0, RegWEn=0, and no stale writes appear.
